// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle for pc_sequencer: instruction-memory req/ack, decode valid/ready,
// redirect/halt control and PC status. master = sequencer, slave = memory/decode/core side.
interface pc_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        halted;
   logic        fetch_err;
   logic [31:0] pcout;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc, halted, fetch_err, pcout,
      input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc, halt
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, halted, fetch_err, pcout,
      output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc, halt
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter fetch sequencer: one outstanding imem fetch, decode handshake, redirect/halt.
// Optional fetch watchdog enabled by defining PC_WATCHDOG_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | one cycle after reset before the first fetch
// ST_FETCH | imem_req high at pcout, waiting for imem_ack
// ST_HOLD  | fetched word presented to decode, waiting for instr_ready
// ST_HALT  | fetching stopped (halt request or watchdog error)
module pc_sequencer #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int unsigned FETCH_TIMEOUT = 64
) (
   input  logic           clk,
   input  logic           reset,
   pc_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        kill_q, kill_d;
   logic [31:0] kill_pc_q, kill_pc_d;
   logic        req_q, req_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;
   logic        err_hold;

`ifdef PC_WATCHDOG_EN
   logic        err_q, err_d;
   logic [31:0] wd_cnt_q, wd_cnt_d;
`else
   logic        unused_timeout;
   assign unused_timeout = ^FETCH_TIMEOUT;
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      kill_d     = kill_q;
      kill_pc_d  = kill_pc_q;
      err_hold   = 1'b0;
`ifdef PC_WATCHDOG_EN
      err_d      = err_q;
      wd_cnt_d   = wd_cnt_q;
      err_hold   = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.redirect_valid) pc_d = bus.redirect_pc;
            state_d = bus.halt ? ST_HALT : ST_FETCH;
         end
         ST_FETCH: begin
            if (bus.imem_ack) begin
               // A redirect (new or pending) turns this completion into a discarded fetch.
               if (bus.redirect_valid) begin
                  pc_d   = bus.redirect_pc;
                  kill_d = 1'b0;
               end else if (kill_q) begin
                  pc_d   = kill_pc_q;
                  kill_d = 1'b0;
               end else begin
                  instr_d    = bus.imem_rdata;
                  instr_pc_d = pc_q;
                  pc_d       = pc_q + 32'd1;
                  state_d    = ST_HOLD;
               end
            end else begin
               if (bus.redirect_valid) begin
                  kill_d    = 1'b1;
                  kill_pc_d = bus.redirect_pc;
               end
`ifdef PC_WATCHDOG_EN
               if (wd_cnt_q == '0) begin
                  err_d   = 1'b1;
                  state_d = ST_HALT;
               end else begin
                  wd_cnt_d = wd_cnt_q - 32'd1;
               end
`endif
            end
         end
         ST_HOLD: begin
            if (bus.redirect_valid) begin
               pc_d    = bus.redirect_pc;
               state_d = bus.halt ? ST_HALT : ST_FETCH;
            end else if (bus.instr_ready) begin
               state_d = bus.halt ? ST_HALT : ST_FETCH;
            end
         end
         ST_HALT: begin
            if (bus.redirect_valid) pc_d = bus.redirect_pc;
            if (!bus.halt && !err_hold) state_d = ST_FETCH;
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef PC_WATCHDOG_EN
      // Every new fetch attempt (including the one after a discarded completion) gets a full budget.
      if (state_d == ST_FETCH && (state_q != ST_FETCH || bus.imem_ack))
         wd_cnt_d = FETCH_TIMEOUT - 32'd1;
`endif
      req_d    = (state_d == ST_FETCH);
      valid_d  = (state_d == ST_HOLD);
      halted_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         instr_pc_q <= '0;
         kill_q     <= 1'b0;
         kill_pc_q  <= '0;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
`ifdef PC_WATCHDOG_EN
         err_q      <= 1'b0;
         wd_cnt_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         kill_q     <= kill_d;
         kill_pc_q  <= kill_pc_d;
         req_q      <= req_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
`ifdef PC_WATCHDOG_EN
         err_q      <= err_d;
         wd_cnt_q   <= wd_cnt_d;
`endif
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = pc_q;
   assign bus.pcout       = pc_q;
   assign bus.instr_valid = valid_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.halted      = halted_q;
`ifdef PC_WATCHDOG_EN
   assign bus.fetch_err   = err_q;
`else
   assign bus.fetch_err   = 1'b0;
`endif

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch sequencer that owns the program counter register and drives instruction-memory fetches for the single-issue core. It issues one fetch at a time over a req/ack handshake, presents the fetched word to decode over a valid/ready handshake, and applies branch/jump redirects and halt requests. It replaces the free-running PC update with an explicit state machine, so memory wait states and decode back-pressure stall the PC correctly.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- FETCH_TIMEOUT, 64, cycles a fetch may wait for ack before erroring; only used with PC_WATCHDOG_EN

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset asynchronous active-high
- imem_req  out  1  fetch request, high while in FETCH
- imem_addr  out  32  word address of fetch, equals pcout
- imem_ack  in  1  memory completes fetch this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack
- instr_valid  out  1  instr/instr_pc hold a live instruction
- instr_ready  in  1  decode accepts instruction this cycle
- instr  out  32  fetched instruction
- instr_pc  out  32  address instr was fetched from
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  32  redirect target (word address)
- halt  in  1  level request to stop fetching
- halted  out  1  high in HALT state
- fetch_err  out  1  sticky watchdog error
- pcout  out  32  current PC register

## Operation
- States: IDLE, FETCH, HOLD, HALT. Reset enters IDLE.
- IDLE: next edge -> FETCH (or HALT if halt=1).
- FETCH: imem_req=1, imem_addr=pcout held stable until imem_ack. On ack: instr<=imem_rdata, instr_pc<=pcout, pcout<=pcout+1, -> HOLD.
- HOLD: instr_valid=1. On instr_ready: -> HALT if halt=1, else -> FETCH. Without ready, instr/instr_pc hold.
- HALT: halted=1, imem_req=0; halt=0 -> FETCH.
- Redirect in FETCH without ack: set kill flag, store target; keep req high until ack; on ack discard data, pcout<=stored target, clear kill, stay in FETCH.
- Redirect coincident with ack in FETCH: discard data, pcout<=redirect_pc, stay FETCH.
- Redirect in HOLD: held instruction killed (instr_valid=0 next cycle, regardless of instr_ready), pcout<=redirect_pc, -> FETCH (HALT if halt=1).
- Redirect in IDLE/HALT: pcout<=redirect_pc, state unchanged.
- Later redirect overwrites an earlier pending one.
- pcout+1 wraps 32'hFFFF_FFFF -> 32'h0000_0000.

## Timing
- Reset values: pcout=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, halted=0, fetch_err=0, kill flag=0.
- Reset mid-handshake abandons the fetch immediately (req drops asynchronously).
- imem_req, imem_addr, instr_valid, halted are decoded from registered state/PC: no combinational path from any input.
- Zero-wait memory (ack same cycle as req): 2 cycles per instruction (FETCH, HOLD); each ack wait cycle adds 1.
- First imem_req: cycle 2 after reset deasserts (IDLE, then FETCH).
- Redirect target appears on imem_addr the cycle after the accepting edge.

## Configuration
- PC_WATCHDOG_EN defined: counter clears on entering FETCH, increments each FETCH cycle without ack; reaching FETCH_TIMEOUT sets fetch_err (sticky until reset), drops imem_req, forces HALT; halt=0 does not leave HALT while fetch_err=1.
- Undefined: no counter, fetch_err tied 0, FETCH waits indefinitely.

## Test plan
- Reset with RESET_PC=32'h100, ack same cycle, ready=1 -> imem_addr 0x100,0x101,0x102 on every other cycle; instr_pc matches; pcout 0x103 after third.
- Ack delayed 3 cycles -> imem_req and imem_addr=0x100 stable all 4 cycles; single instr_valid pulse per fetch.
- instr_ready low 5 cycles in HOLD -> instr constant, no new imem_req; redirect to 0x40 then -> instr_valid drops, next fetch at 0x40.
- Redirect to 0x200 during delayed fetch of 0x10 -> 0x10 data never reaches instr_valid; next imem_addr 0x200.
- RESET_PC=32'hFFFF_FFFF -> second fetch address 0x0; halt=1 in HOLD with ready -> halted=1, no req until halt=0.
- PC_WATCHDOG_EN, FETCH_TIMEOUT=8, ack never arrives -> fetch_err=1 and halted=1 after 8 FETCH cycles; remains until reset.
